// File: rtl/pixel_stream_generator.sv
// -----------------------------------------------------------------------------
// pixel_stream_generator
//
// Synthesisable RGB test-pattern source for bring-up of the video pipeline.
// Produces the DATA_VALID / RED / GREEN / BLUE stream consumed by the gamma,
// Bayer and colour-space IPs, line by line, with programmable inter-line
// (H_BLANK) and inter-frame (V_BLANK) idle gaps.
//
// Ports:
//   SYS_CLK_I      system clock, rising edge
//   RESET_I        asynchronous active-high reset
//   ENABLE_I       run request, sampled in IDLE and at frame end only
//   H_RES_I        active pixels per line
//   V_RES_I        active lines per frame
//   H_BLANK_I      idle cycles after each line (0 = back-to-back lines)
//   V_BLANK_I      idle cycles after the last line of a frame
//   PATTERN_SEL_I  0 colour bars, 1 ramp, 2 checker, 3 moving diagonal
//   DATA_VALID_O   pixel valid
//   RED_O/GREEN_O/BLUE_O  pixel components (hold while not valid)
//   EOL_O          last pixel of each line
//   EOF_O          last pixel of each frame
//
// Optional build macro PIXEL_STREAM_GENERATOR_SYNC_OUT_EN adds:
//   H_SYNC_O       1-cycle pulse the cycle after each EOL_O
//   V_SYNC_O       1-cycle pulse the cycle after each EOF_O
//   H_ACTIVE_O     equal to DATA_VALID_O
//   V_ACTIVE_O     high from first to last pixel of a frame, incl. line gaps
// -----------------------------------------------------------------------------
module pixel_stream_generator #(
   parameter int G_DATA_WIDTH = 8,
   parameter int G_HRES_WIDTH = 11,
   parameter int G_VRES_WIDTH = 11
) (
   input  logic                    SYS_CLK_I,
   input  logic                    RESET_I,
   input  logic                    ENABLE_I,
   input  logic [G_HRES_WIDTH-1:0] H_RES_I,
   input  logic [G_VRES_WIDTH-1:0] V_RES_I,
   input  logic [G_HRES_WIDTH-1:0] H_BLANK_I,
   input  logic [G_VRES_WIDTH-1:0] V_BLANK_I,
   input  logic [1:0]              PATTERN_SEL_I,
   output logic                    DATA_VALID_O,
   output logic [G_DATA_WIDTH-1:0] RED_O,
   output logic [G_DATA_WIDTH-1:0] GREEN_O,
   output logic [G_DATA_WIDTH-1:0] BLUE_O,
   output logic                    EOL_O,
   output logic                    EOF_O
`ifdef PIXEL_STREAM_GENERATOR_SYNC_OUT_EN
   ,
   output logic                    H_SYNC_O,
   output logic                    V_SYNC_O,
   output logic                    H_ACTIVE_O,
   output logic                    V_ACTIVE_O
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_HBLANK = 2'd2,
      S_VBLANK = 2'd3
   } state_t;

   localparam logic [G_HRES_WIDTH-1:0] H_ZERO = {G_HRES_WIDTH{1'b0}};
   localparam logic [G_HRES_WIDTH-1:0] H_ONE  = {{(G_HRES_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [G_VRES_WIDTH-1:0] V_ZERO = {G_VRES_WIDTH{1'b0}};
   localparam logic [G_VRES_WIDTH-1:0] V_ONE  = {{(G_VRES_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [G_DATA_WIDTH-1:0] D_ZERO = {G_DATA_WIDTH{1'b0}};
   localparam logic [G_DATA_WIDTH-1:0] D_ONE  = {{(G_DATA_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [G_DATA_WIDTH-1:0] D_MAX  = {G_DATA_WIDTH{1'b1}};

   // Horizontal count reduced modulo 2^G_DATA_WIDTH (zero-extended first so
   // any ratio of counter width to data width is legal).
   function automatic logic [G_DATA_WIDTH-1:0] h_mod(input logic [G_HRES_WIDTH-1:0] val);
      logic [G_HRES_WIDTH+G_DATA_WIDTH-1:0] ext;
      ext = {{G_DATA_WIDTH{1'b0}}, val};
      return ext[G_DATA_WIDTH-1:0];
   endfunction

   // Vertical count reduced modulo 2^G_DATA_WIDTH.
   function automatic logic [G_DATA_WIDTH-1:0] v_mod(input logic [G_VRES_WIDTH-1:0] val);
      logic [G_VRES_WIDTH+G_DATA_WIDTH-1:0] ext;
      ext = {{G_DATA_WIDTH{1'b0}}, val};
      return ext[G_DATA_WIDTH-1:0];
   endfunction

   // Bar colour for index 0..7 (white, yellow, cyan, green, magenta, red,
   // blue, black). Each component is simply an inverted bit of the index.
   function automatic logic [3*G_DATA_WIDTH-1:0] bar_rgb(input logic [2:0] idx);
      logic [G_DATA_WIDTH-1:0] r;
      logic [G_DATA_WIDTH-1:0] g;
      logic [G_DATA_WIDTH-1:0] b;
      r = idx[1] ? D_ZERO : D_MAX;
      g = idx[2] ? D_ZERO : D_MAX;
      b = idx[0] ? D_ZERO : D_MAX;
      return {r, g, b};
   endfunction

   state_t                  state_r;
   state_t                  state_s;
   logic [G_HRES_WIDTH-1:0] x_r, x_s;
   logic [G_VRES_WIDTH-1:0] y_r, y_s;
   logic [G_HRES_WIDTH-1:0] hcnt_r, hcnt_s;
   logic [G_VRES_WIDTH-1:0] vcnt_r, vcnt_s;
   logic [G_HRES_WIDTH-1:0] bar_cnt_r, bar_cnt_s;
   logic [2:0]              bar_idx_r, bar_idx_s;
   logic [G_DATA_WIDTH-1:0] frame_r;

   // Configuration captured at frame start
   logic [G_HRES_WIDTH-1:0] hres_r;
   logic [G_VRES_WIDTH-1:0] vres_r;
   logic [G_HRES_WIDTH-1:0] hblank_r;
   logic [G_VRES_WIDTH-1:0] vblank_r;
   logic [1:0]              pat_r;
   logic [G_HRES_WIDTH-1:0] bw_r;
   logic [G_HRES_WIDTH-1:0] bw_in_s;

   logic start_ok_s;
   logic last_px_s;
   logic last_ln_s;
   logic latch_s;
   logic frame_inc_s;
   logic frame_end_s;
   logic emit_s;

   logic [G_DATA_WIDTH-1:0] red_s;
   logic [G_DATA_WIDTH-1:0] green_s;
   logic [G_DATA_WIDTH-1:0] blue_s;

   assign start_ok_s = ENABLE_I && (H_RES_I != H_ZERO) && (V_RES_I != V_ZERO);
   assign last_px_s  = (x_r == hres_r - H_ONE);
   assign last_ln_s  = (y_r == vres_r - V_ONE);

   // Bar width from the requested line length; narrow lines use width 1.
   always_comb begin
      bw_in_s = H_RES_I >> 3;
      if (bw_in_s == H_ZERO) begin
         bw_in_s = H_ONE;
      end else begin
         bw_in_s = H_RES_I >> 3;
      end
   end

   // Next-state and counter logic for the raster FSM.
   always_comb begin
      state_s     = state_r;
      x_s         = x_r;
      y_s         = y_r;
      hcnt_s      = hcnt_r;
      vcnt_s      = vcnt_r;
      bar_cnt_s   = bar_cnt_r;
      bar_idx_s   = bar_idx_r;
      latch_s     = 1'b0;
      frame_inc_s = 1'b0;
      frame_end_s = 1'b0;
      emit_s      = 1'b0;

      case (state_r)
         S_IDLE: begin
            if (start_ok_s) begin
               latch_s = 1'b1;
               state_s = S_ACTIVE;
            end else begin
               state_s = S_IDLE;
            end
         end

         S_ACTIVE: begin
            emit_s = 1'b1;
            if (last_px_s) begin
               x_s       = H_ZERO;
               bar_cnt_s = H_ZERO;
               bar_idx_s = 3'd0;
               if (last_ln_s) begin
                  // The last line's trailing H_BLANK is absorbed by V_BLANK.
                  y_s = V_ZERO;
                  if (vblank_r == V_ZERO) begin
                     frame_end_s = 1'b1;
                  end else begin
                     state_s = S_VBLANK;
                     vcnt_s  = V_ZERO;
                  end
               end else begin
                  y_s = y_r + V_ONE;
                  if (hblank_r == H_ZERO) begin
                     state_s = S_ACTIVE;
                  end else begin
                     state_s = S_HBLANK;
                     hcnt_s  = H_ZERO;
                  end
               end
            end else begin
               x_s = x_r + H_ONE;
               // Bar index steps every bw_r pixels and sticks at black.
               if (bar_cnt_r == bw_r - H_ONE) begin
                  bar_cnt_s = H_ZERO;
                  if (bar_idx_r != 3'd7) begin
                     bar_idx_s = bar_idx_r + 3'd1;
                  end else begin
                     bar_idx_s = 3'd7;
                  end
               end else begin
                  bar_cnt_s = bar_cnt_r + H_ONE;
               end
            end
         end

         S_HBLANK: begin
            if (hcnt_r == hblank_r - H_ONE) begin
               state_s = S_ACTIVE;
            end else begin
               hcnt_s = hcnt_r + H_ONE;
            end
         end

         S_VBLANK: begin
            if (vcnt_r == vblank_r - V_ONE) begin
               frame_end_s = 1'b1;
            end else begin
               vcnt_s = vcnt_r + V_ONE;
            end
         end

         default: begin
            state_s = S_IDLE;
         end
      endcase

      // Frame boundary: either chain straight into the next frame with fresh
      // configuration, or park in IDLE.
      if (frame_end_s) begin
         if (start_ok_s) begin
            latch_s     = 1'b1;
            frame_inc_s = 1'b1;
            state_s     = S_ACTIVE;
         end else begin
            state_s = S_IDLE;
         end
      end else begin
         frame_inc_s = 1'b0;
      end
   end

   // FSM state and raster counters.
   always_ff @(posedge SYS_CLK_I or posedge RESET_I) begin
      if (RESET_I) begin
         state_r   <= S_IDLE;
         x_r       <= H_ZERO;
         y_r       <= V_ZERO;
         hcnt_r    <= H_ZERO;
         vcnt_r    <= V_ZERO;
         bar_cnt_r <= H_ZERO;
         bar_idx_r <= 3'd0;
      end else begin
         state_r   <= state_s;
         x_r       <= x_s;
         y_r       <= y_s;
         hcnt_r    <= hcnt_s;
         vcnt_r    <= vcnt_s;
         bar_cnt_r <= bar_cnt_s;
         bar_idx_r <= bar_idx_s;
      end
   end

   // Configuration capture at frame start and frame counter.
   always_ff @(posedge SYS_CLK_I or posedge RESET_I) begin
      if (RESET_I) begin
         hres_r   <= H_ZERO;
         vres_r   <= V_ZERO;
         hblank_r <= H_ZERO;
         vblank_r <= V_ZERO;
         pat_r    <= 2'd0;
         bw_r     <= H_ONE;
         frame_r  <= D_ZERO;
      end else begin
         if (latch_s) begin
            hres_r   <= H_RES_I;
            vres_r   <= V_RES_I;
            hblank_r <= H_BLANK_I;
            vblank_r <= V_BLANK_I;
            pat_r    <= PATTERN_SEL_I;
            bw_r     <= bw_in_s;
         end else begin
            hres_r   <= hres_r;
            vres_r   <= vres_r;
            hblank_r <= hblank_r;
            vblank_r <= vblank_r;
            pat_r    <= pat_r;
            bw_r     <= bw_r;
         end
         if (frame_inc_s) begin
            frame_r <= frame_r + D_ONE;
         end else begin
            frame_r <= frame_r;
         end
      end
   end

   // Pixel value for the current raster position.
   always_comb begin
      red_s   = D_ZERO;
      green_s = D_ZERO;
      blue_s  = D_ZERO;
      case (pat_r)
         2'd0: begin
            {red_s, green_s, blue_s} = bar_rgb(bar_idx_r);
         end
         2'd1: begin
            red_s   = h_mod(x_r);
            green_s = h_mod(x_r);
            blue_s  = h_mod(x_r);
         end
         2'd2: begin
            if (x_r[3] ^ y_r[3]) begin
               red_s   = D_MAX;
               green_s = D_MAX;
               blue_s  = D_MAX;
            end else begin
               red_s   = D_ZERO;
               green_s = D_ZERO;
               blue_s  = D_ZERO;
            end
         end
         2'd3: begin
            red_s   = h_mod(x_r) + v_mod(y_r) + frame_r;
            green_s = h_mod(x_r);
            blue_s  = v_mod(y_r);
         end
         default: begin
            red_s   = D_ZERO;
            green_s = D_ZERO;
            blue_s  = D_ZERO;
         end
      endcase
   end

   // Registered pixel outputs; colour holds between valid cycles.
   always_ff @(posedge SYS_CLK_I or posedge RESET_I) begin
      if (RESET_I) begin
         DATA_VALID_O <= 1'b0;
         RED_O        <= D_ZERO;
         GREEN_O      <= D_ZERO;
         BLUE_O       <= D_ZERO;
         EOL_O        <= 1'b0;
         EOF_O        <= 1'b0;
      end else begin
         if (emit_s) begin
            DATA_VALID_O <= 1'b1;
            RED_O        <= red_s;
            GREEN_O      <= green_s;
            BLUE_O       <= blue_s;
            EOL_O        <= last_px_s;
            EOF_O        <= last_px_s && last_ln_s;
         end else begin
            DATA_VALID_O <= 1'b0;
            RED_O        <= RED_O;
            GREEN_O      <= GREEN_O;
            BLUE_O       <= BLUE_O;
            EOL_O        <= 1'b0;
            EOF_O        <= 1'b0;
         end
      end
   end

`ifdef PIXEL_STREAM_GENERATOR_SYNC_OUT_EN
   // Sync and active-window flags derived from the pixel stream.
   always_ff @(posedge SYS_CLK_I or posedge RESET_I) begin
      if (RESET_I) begin
         H_SYNC_O   <= 1'b0;
         V_SYNC_O   <= 1'b0;
         H_ACTIVE_O <= 1'b0;
         V_ACTIVE_O <= 1'b0;
      end else begin
         H_SYNC_O   <= EOL_O;
         V_SYNC_O   <= EOF_O;
         H_ACTIVE_O <= emit_s;
         V_ACTIVE_O <= (state_r == S_ACTIVE) || (state_r == S_HBLANK);
      end
   end
`endif

endmodule

// File: tb/tb_pixel_stream_generator.sv
module tb_pixel_stream_generator;

   localparam int DW  = 8;
   localparam int HW  = 11;
   localparam int VW  = 11;
   localparam int MAX = (1 << DW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [HW-1:0] hres;
   logic [VW-1:0] vres;
   logic [HW-1:0] hblank;
   logic [VW-1:0] vblank;
   logic [1:0]    pat;
   logic          valid;
   logic [DW-1:0] red, green, blue;
   logic          eol, eof;
`ifdef PIXEL_STREAM_GENERATOR_SYNC_OUT_EN
   logic          hsync, vsync, hact, vact;
`endif

   pixel_stream_generator #(
      .G_DATA_WIDTH (DW),
      .G_HRES_WIDTH (HW),
      .G_VRES_WIDTH (VW)
   ) dut (
      .SYS_CLK_I     (clk),
      .RESET_I       (rst),
      .ENABLE_I      (en),
      .H_RES_I       (hres),
      .V_RES_I       (vres),
      .H_BLANK_I     (hblank),
      .V_BLANK_I     (vblank),
      .PATTERN_SEL_I (pat),
      .DATA_VALID_O  (valid),
      .RED_O         (red),
      .GREEN_O       (green),
      .BLUE_O        (blue),
      .EOL_O         (eol),
      .EOF_O         (eof)
`ifdef PIXEL_STREAM_GENERATOR_SYNC_OUT_EN
      ,
      .H_SYNC_O      (hsync),
      .V_SYNC_O      (vsync),
      .H_ACTIVE_O    (hact),
      .V_ACTIVE_O    (vact)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { int h; int v; int hb; int vb; int pat; } cfg_t;
   typedef struct { int r; int g; int b; bit eol; bit eof; int gap; } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   popped = 0;
   int   model_frame = 0;

   // Colour bar table: white, yellow, cyan, green, magenta, red, blue, black
   int bar_r[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
   int bar_g[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
   int bar_b[8] = '{1, 0, 1, 0, 1, 0, 1, 0};

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference pixel computed directly from the pattern definitions.
   task automatic model_pixel(input cfg_t c, input int x, input int y, input int f,
                              output int r, output int g, output int b);
      int w, idx;
      case (c.pat)
         0: begin
            w = c.h / 8;
            if (w == 0) w = 1;
            idx = x / w;
            if (idx > 7) idx = 7;
            r = bar_r[idx] * MAX; g = bar_g[idx] * MAX; b = bar_b[idx] * MAX;
         end
         1: begin r = x % (MAX + 1); g = r; b = r; end
         2: begin r = ((((x / 8) + (y / 8)) % 2) == 1) ? MAX : 0; g = r; b = r; end
         default: begin
            r = (x + y + f) % (MAX + 1); g = x % (MAX + 1); b = y % (MAX + 1);
         end
      endcase
   endtask

   task automatic push_frames(input cfg_t a, input cfg_t b, input int n);
      cfg_t c;
      exp_t e;
      int   prev_vb;
      prev_vb = a.vb;
      for (int k = 0; k < n; k++) begin
         c = (k == 0) ? a : b;
         for (int y = 0; y < c.v; y++) begin
            for (int x = 0; x < c.h; x++) begin
               model_pixel(c, x, y, (model_frame + k) % (MAX + 1), e.r, e.g, e.b);
               e.eol = (x == c.h - 1);
               e.eof = (x == c.h - 1) && (y == c.v - 1);
               if (x == 0 && y == 0) e.gap = (k == 0) ? -1 : prev_vb;
               else if (x == 0)      e.gap = c.hb;
               else                  e.gap = 0;
               q.push_back(e);
            end
         end
         prev_vb = c.vb;
      end
      model_frame = (model_frame + n - 1) % (MAX + 1);
   endtask

   task automatic apply_cfg(input cfg_t c);
      hres   = HW'(c.h);
      vres   = VW'(c.v);
      hblank = HW'(c.hb);
      vblank = VW'(c.vb);
      pat    = 2'(c.pat);
   endtask

   task automatic wait_popped(input int target, input string name);
      int n = 0;
      while (popped < target && n < 5000) begin
         @(negedge clk); #1;
         n++;
      end
      check({name, "_reached"}, int'(popped >= target), 1);
   endtask

   task automatic drain(input int extra);
      int n = 0;
      while (q.size() != 0 && n < 5000) begin
         @(negedge clk); #1;
         n++;
      end
      check("drain_empty", q.size(), 0);
      repeat (extra) @(negedge clk);
      #1;
   endtask

   // Frame 1 uses a, later frames b; inputs switch to b after the first pixel
   // and ENABLE drops halfway through the final frame.
   task automatic run_seq(input cfg_t a, input cfg_t b, input int n);
      int   base, before_last;
      cfg_t last;
      base = popped;
      apply_cfg(a);
      push_frames(a, b, n);
      en = 1'b1;
      wait_popped(base + 1, "first_pixel");
      apply_cfg(b);
      before_last = base + ((n > 1) ? a.h * a.v + (n - 2) * b.h * b.v : 0);
      last = (n > 1) ? b : a;
      wait_popped(before_last + (last.h * last.v) / 2 + 1, "mid_last_frame");
      en = 1'b0;
      drain(last.vb + 6);
   endtask

   function automatic cfg_t mk(input int h, input int v, input int hb, input int vb, input int p);
      cfg_t c;
      c.h = h; c.v = v; c.hb = hb; c.vb = vb; c.pat = p;
      return c;
   endfunction

   function automatic cfg_t rand_cfg();
      cfg_t c;
      do begin
         c.h = int'($urandom_range(1, 24));
         c.v = int'($urandom_range(1, 5));
      end while (c.h * c.v < 8);
      c.hb  = int'($urandom_range(0, 4));
      c.vb  = int'($urandom_range(0, 4));
      c.pat = int'($urandom_range(0, 3));
      return c;
   endfunction

   // Monitor: pops the scoreboard on every valid cycle.
   int   gap_cnt = 0;
   int   last_r = 0, last_g = 0, last_b = 0;
   exp_t e_mon;
   bit   cur_valid, prev_eol = 0, prev_eof = 0, vopen = 0;

   always @(negedge clk) begin
      if (rst) begin
         gap_cnt = 0; last_r = 0; last_g = 0; last_b = 0;
         prev_eol = 0; prev_eof = 0; vopen = 0;
      end else begin
         cur_valid = 0;
         if (valid) begin
            if (q.size() == 0) begin
               check("unexpected_pixel", 1, 0);
            end else begin
               e_mon = q.pop_front();
               cur_valid = 1;
               check("red",   int'(red),   e_mon.r);
               check("green", int'(green), e_mon.g);
               check("blue",  int'(blue),  e_mon.b);
               check("eol",   int'(eol),   int'(e_mon.eol));
               check("eof",   int'(eof),   int'(e_mon.eof));
               if (e_mon.gap >= 0) check("gap", gap_cnt, e_mon.gap);
               last_r = e_mon.r; last_g = e_mon.g; last_b = e_mon.b;
               popped++;
            end
            gap_cnt = 0;
         end else begin
            gap_cnt++;
            check("eol_idle", int'(eol), 0);
            check("eof_idle", int'(eof), 0);
            check("rgb_hold", int'({red, green, blue}), (last_r << 16) | (last_g << 8) | last_b);
         end
`ifdef PIXEL_STREAM_GENERATOR_SYNC_OUT_EN
         check("h_sync",   int'(hsync), int'(prev_eol));
         check("v_sync",   int'(vsync), int'(prev_eof));
         check("h_active", int'(hact),  int'(cur_valid));
         check("v_active", int'(vact),  int'(cur_valid || vopen));
`endif
         prev_eol = cur_valid && e_mon.eol;
         prev_eof = cur_valid && e_mon.eof;
         if (cur_valid) vopen = !e_mon.eof;
      end
   end

   initial begin
      cfg_t c, c2;
      int   base;
      rst = 1'b1; en = 1'b0;
      apply_cfg(mk(0, 0, 0, 0, 0));
      repeat (3) @(negedge clk);
      #1;
      check("reset_valid", int'(valid), 0);
      check("reset_rgb",   int'({red, green, blue}), 0);
      check("reset_eol",   int'(eol), 0);
      check("reset_eof",   int'(eof), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;

      // Diagonal over two frames: frame counter 0 then 1
      c = mk(8, 2, 1, 2, 3);
      run_seq(c, c, 2);
      // Colour bars with line gaps, then remainder pixels black
      c = mk(16, 4, 3, 2, 0);
      run_seq(c, c, 1);
      c = mk(20, 2, 0, 0, 0);
      run_seq(c, c, 1);
      // Long ramp line, back-to-back lines, V_BLANK of 10
      c = mk(640, 2, 0, 10, 1);
      run_seq(c, c, 2);
      // Mid-frame config changes only affect the following frame
      c  = mk(16, 4, 1, 2, 0);
      c2 = mk(8, 4, 0, 1, 2);
      run_seq(c, c2, 1);
      run_seq(c, c2, 3);

      // Zero resolution keeps the generator idle
      apply_cfg(mk(0, 3, 1, 1, 1));
      en = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      check("zero_hres_idle", int'(valid), 0);
      apply_cfg(mk(5, 0, 1, 1, 1));
      repeat (20) @(negedge clk);
      #1;
      check("zero_vres_idle", int'(valid), 0);
      en = 1'b0;
      repeat (3) @(negedge clk);
      #1;

      // Reset mid-frame aborts and clears the frame counter
      c = mk(16, 4, 2, 2, 3);
      base = popped;
      apply_cfg(c);
      push_frames(c, c, 1);
      en = 1'b1;
      wait_popped(base + 5, "pre_reset");
      check("pre_reset_valid", int'(valid), 1);
      rst = 1'b1;
      #1;
      check("abort_valid", int'(valid), 0);
      check("abort_rgb",   int'({red, green, blue}), 0);
      check("abort_eol",   int'(eol), 0);
      q.delete();
      model_frame = 0;
      repeat (2) @(negedge clk);
      #1;
      base = popped;
      push_frames(c, c, 1);
      rst = 1'b0;
      wait_popped(base + 33, "post_reset");
      en = 1'b0;
      drain(c.vb + 6);

      // Randomised runs
      for (int i = 0; i < 8; i++) begin
         c  = rand_cfg();
         c2 = ($urandom_range(0, 1) == 1) ? rand_cfg() : c;
         run_seq(c, c2, int'($urandom_range(1, 3)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
